uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Standalone oversampling UART receiver, the receive end of the team's UART link, paired with the existing transmitter. It synchronises the asynchronous serial line and validates the start bit. It takes a three-sample majority vote at each bit centre, checks optional parity and the stop bit, and presents each received byte on a valid/ready output with error and overrun flags. It replaces the loopback-only receive path so that external or noisy lines are handled robustly.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per bit (C); legal range is C ≥ 8.
- PARITY_EN, default 0: 1 adds one parity bit between data and stop.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN = 0.
- clk_in  input  1  single clock; all logic is on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idle high; LSB first.
- rx_data_out  output  8  received byte; stable while rx_valid_out = 1.
- rx_valid_out  output  1  byte available; held until accepted.
- rx_ready_in  input  1  consumer accepts the byte when rx_valid_out & rx_ready_in.
- parity_err_out  output  1  parity mismatch for the byte currently on rx_data_out; qualified by rx_valid_out.
- frame_err_out  output  1  one-cycle pulse when the stop bit is sampled 0.
- overrun_out  output  1  one-cycle pulse when a good frame arrives while the previous byte is unaccepted.
- busy_out  output  1  high in every state except IDLE.

## Operation
- Synchroniser: two flops give rx_s; a third flop gives rx_p (rx_s delayed one cycle).
- Bit timing: the counter cnt runs 0..C−1 per bit period.
  - Nominal centre is M = C/2 (integer division).
  - Samples are taken at cnt = M−1, M and M+1; the bit value is the majority of the three.
  - The decision is made at cnt = M+1.
- State IDLE: on rx_p = 1 and rx_s = 0, go to START with cnt = 0 and bit index 0.
- State START: at the decision point:
  - Majority 1 means a false start; return to IDLE.
  - Majority 0 means continue; go to DATA at cnt = C−1.
- State DATA: eight bits, LSB first, shifted into a shift register.
  - After bit 7, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
- State PARITY: the sampled bit is XORed with the data XOR. A nonzero result when PARITY_ODD = 0, or zero when PARITY_ODD = 1, sets a pending parity error.
- State STOP: at the decision point, return to IDLE immediately without waiting for the end of the stop bit.
  - Stop bit 0: pulse frame_err_out; the byte is discarded and rx_valid_out does not change.
  - Stop bit 1 and the output register is free (rx_valid_out = 0, or a handshake in this same cycle): load rx_data_out and parity_err_out, and set rx_valid_out.
  - Stop bit 1 and the output register is occupied with no handshake: pulse overrun_out; the new byte is dropped and the old byte and flags are kept.
- Handshake: rx_valid_out & rx_ready_in clears rx_valid_out next cycle unless a new byte loads in that same cycle; in that case rx_valid_out stays 1 with the new data.
- Reset, including mid-frame: go to IDLE, clear cnt and the shift register, and set the synchroniser flops to 1.
  - Reception resumes only after a fresh 1→0 edge on rx_s.

## Timing
- Reset values: rx_data_out = 0, rx_valid_out = 0, parity_err_out = 0, frame_err_out = 0, overrun_out = 0, busy_out = 0.
- Let F be the first clock edge at which rx_in is sampled low.
- Latency for 8N1: rx_valid_out, frame_err_out or overrun_out appears in cycle F + 9·C + M + 5. With PARITY_EN = 1, add C.
- A line low pulse shorter than M−1 cycles never produces output.
- A single-cycle glitch on any one bit sample is rejected by the majority vote.
- Back-to-back frames with a one-bit stop are received without loss.
- Tolerated baud mismatch is about ±4 %.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the shared default CLKS_PER_BIT and frame constants (8 data bits), shared with the transmitter.
- Sub-module uart_rx_sync: two-flop synchroniser plus edge register, outputs rx_s and rx_p. It is reusable for other asynchronous inputs.
- The three-sample voter and counter are inline in the FSM.

## Test plan
All scenarios use C = 16 (M = 8).
- Send 0xA5 as 8N1, with a one-cycle glitch at the centre of bit 2 → rx_valid_out = 1 at F+157, rx_data_out = 0xA5, all errors 0.
- Drive rx_in low for 4 cycles, then high → no output, busy_out returns to 0 by F+12, a following 0x3C frame is received correctly.
- Send 0x3C with stop bit 0 → frame_err_out high for exactly one cycle at F+157, rx_valid_out stays 0.
- Set PARITY_EN = 1 (even) and send 0x07 with parity bit 0 → valid at F+173, data 0x07, parity_err_out = 1. With parity bit 1 → parity_err_out = 0.
- Hold rx_ready_in = 0 and send 0x11 then 0x22 → overrun_out pulses once, rx_data_out stays 0x11. Raising rx_ready_in accepts 0x11 and rx_valid_out falls next cycle.
- Assert rst_in for 1 cycle during data bit 3 → all outputs 0 next cycle, no partial byte emitted, a subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg - UART receive/transmit shared state encoding and frame constants  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned C_DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned C_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sampler_if - received-byte valid/ready channel plus status pulses   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic [C_DATA_BITS-1:0] rx_data_out;
  logic                   rx_valid_out;
  logic                   rx_ready_in;
  logic                   parity_err_out;
  logic                   frame_err_out;
  logic                   overrun_out;
  logic                   busy_out;

  modport master (
    output rx_data_out, rx_valid_out, parity_err_out, frame_err_out, overrun_out, busy_out,
    input  rx_ready_in
  );

  modport slave (
    input  rx_data_out, rx_valid_out, parity_err_out, frame_err_out, overrun_out, busy_out,
    output rx_ready_in
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sync - two-flop synchroniser plus one-cycle-delayed copy for edges  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic prev_o
);

  logic meta_q, sync_q, prev_q;

  // Resetting to the idle level means a line already low at reset release still needs a 1->0 edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign prev_o = prev_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sampler - oversampling UART receiver with 3-sample majority voting  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rx_in,
  uart_rx_sampler_if.master rx_if
);

  localparam int unsigned     CW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned     MID        = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]   C_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   C_S0       = CW'(MID - 1);
  localparam logic [CW-1:0]   C_S1       = CW'(MID);
  localparam logic [CW-1:0]   C_DEC      = CW'(MID + 1);
  localparam logic [2:0]      C_LAST_BIT = 3'(C_DATA_BITS - 1);

  logic                   w_rx_s, w_rx_p;
  logic                   w_vote, w_decide, w_bit_end, w_accept;
  rx_state_e              state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_idx_q;
  logic [C_DATA_BITS-1:0] shift_q, data_q;
  logic [1:0]             samp_q;
  logic                   par_err_q, done_q, stop_ok_q;
  logic                   valid_q, perr_q, ferr_q, ovr_q, busy_q;

  uart_rx_sync u_sync (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .async_i (rx_in),
    .sync_o  (w_rx_s),
    .prev_o  (w_rx_p)
  );

  assign w_bit_end = (cnt_q == C_LAST);
  assign w_decide  = (cnt_q == C_DEC);
  assign w_vote    = majority3(samp_q[1], samp_q[0], w_rx_s);
  assign w_accept  = valid_q & rx_if.rx_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      par_err_q <= 1'b0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      done_q <= 1'b0;
      if (w_accept) valid_q <= 1'b0;

      // Stop-bit verdict from the previous cycle lands in the output register here
      if (done_q) begin
        if (!stop_ok_q) begin
          ferr_q <= 1'b1;
        end else if (!valid_q || w_accept) begin
          data_q  <= shift_q;
          perr_q  <= par_err_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      if (cnt_q == C_S0) samp_q[1] <= w_rx_s;
      if (cnt_q == C_S1) samp_q[0] <= w_rx_s;
      if (state_q != IDLE) cnt_q <= w_bit_end ? '0 : cnt_q + CW'(1);

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (w_rx_p && !w_rx_s) begin
            state_q   <= START;
            bit_idx_q <= '0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (w_decide && w_vote) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (w_bit_end) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (w_decide) shift_q <= {w_vote, shift_q[C_DATA_BITS-1:1]};
          if (w_bit_end) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == C_LAST_BIT) state_q <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_decide) par_err_q <= w_vote ^ (^shift_q) ^ PARITY_ODD;
          if (w_bit_end) state_q <= STOP;
        end
        STOP: begin
          if (w_decide) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            stop_ok_q <= w_vote;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data_out    = data_q;
  assign rx_if.rx_valid_out   = valid_q;
  assign rx_if.parity_err_out = perr_q;
  assign rx_if.frame_err_out  = ferr_q;
  assign rx_if.overrun_out    = ovr_q;
  assign rx_if.busy_out       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_sampler - directed table, corner sequences and random frames     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_uart_rx_sampler;

  localparam int C    = 16;
  localparam int M    = C / 2;
  localparam int LAT  = 9 * C + M + 5;
  localparam int LATP = LAT + C;
  localparam int MAXL = 4096;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
    logic       busy;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         pbit;
    bit         stop;
    int         glitch;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_perr;
    bit         e_ferr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rx    = 1'b1;
  logic ready = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic       wave  [MAXL];
  bit         rdyv  [MAXL];
  bit         rstv  [MAXL];
  int         evk   [MAXL];
  logic [7:0] evd   [MAXL];
  obs_t       obs_n [MAXL];
  obs_t       obs_p [MAXL];
  vec_t       tbl   [7];

  uart_rx_sampler_if if_n ();
  uart_rx_sampler_if if_p ();
  assign if_n.rx_ready_in = ready;
  assign if_p.rx_ready_in = ready;

  uart_rx_sampler #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .rx_if(if_n));
  uart_rx_sampler #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .rx_if(if_p));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t grab_n();
    return {if_n.rx_valid_out, if_n.rx_data_out, if_n.parity_err_out,
            if_n.frame_err_out, if_n.overrun_out, if_n.busy_out};
  endfunction

  function automatic obs_t grab_p();
    return {if_p.rx_valid_out, if_p.rx_data_out, if_p.parity_err_out,
            if_p.frame_err_out, if_p.overrun_out, if_p.busy_out};
  endfunction

  function automatic logic maj(input int p);
    int n;
    n = int'(wave[p]) + int'(wave[p+1]) + int'(wave[p+2]);
    return n >= 2;
  endfunction

  task automatic clear_wave();
    for (int k = 0; k < MAXL; k++) begin
      wave[k] = 1'b1; rdyv[k] = 1'b0; rstv[k] = 1'b0; evk[k] = 0; evd[k] = 8'h00;
    end
  endtask

  // Frame bits: start, 8 data LSB first, optional parity, stop; each held C cycles
  task automatic put_frame(input int s, input logic [7:0] d, input bit par, input bit pbit,
                           input bit stop);
    int   n;
    logic b;
    n = par ? 11 : 10;
    for (int j = 0; j < n; j++) begin
      if (j == 0)          b = 1'b0;
      else if (j <= 8)     b = d[j-1];
      else if (j == n - 1) b = stop;
      else                 b = pbit;
      for (int t = 0; t < C; t++) wave[s + j*C + t] = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; rx = 1'b1; ready = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Index k drives the posedge F+k; obs[k] holds outputs after posedge F+k
  task automatic play(input int len);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k > 0) begin
        obs_n[k-1] = grab_n();
        obs_p[k-1] = grab_p();
      end
      if (k < len) begin
        rx = wave[k]; ready = rdyv[k]; rst = rstv[k];
      end
    end
  endtask

  task automatic random_test();
    int         s, gap, p, len, nfail;
    logic [7:0] d, md, mdat;
    logic       stop, ms, mv, pv, acc, efe, eov;
    logic [11:0] expv, actv;
    obs_t       o;
    do_reset();
    clear_wave();
    s = 0;
    for (int f = 0; f < 10; f++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      put_frame(s, d, 1'b0, 1'b0, stop);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          p = s + (b + 1) * C + int'($urandom_range(0, C - 1));
          wave[p] = ~wave[p];
        end
      end
      for (int b = 0; b < 8; b++) md[b] = maj(s + (b + 1) * C + M);
      ms = maj(s + 9 * C + M);
      evk[s + LAT] = ms ? 1 : 2;
      evd[s + LAT] = md;
      gap = int'($urandom_range(0, 12));
      if (!stop && gap == 0) gap = 1;
      s = s + 10 * C + gap;
    end
    len = s + 20;
    for (int k = 0; k < len; k++) rdyv[k] = ($urandom_range(0, 3) != 0);
    play(len);
    mv = 1'b0; mdat = 8'h00; nfail = 0;
    for (int k = 0; k < len && nfail < 8; k++) begin
      pv  = mv;
      acc = pv & rdyv[k];
      efe = 1'b0; eov = 1'b0;
      if (acc) mv = 1'b0;
      if (evk[k] == 2) efe = 1'b1;
      else if (evk[k] == 1) begin
        if (!pv || acc) begin mv = 1'b1; mdat = evd[k]; end
        else eov = 1'b1;
      end
      o    = obs_n[k];
      expv = {mv, mv ? mdat : 8'h00, eov, efe, 1'b0};
      actv = {o.v, o.v ? o.d : 8'h00, o.ov, o.fe, o.v & o.pe};
      if (actv !== expv) nfail++;
      chk($sformatf("random cycle %0d {valid,data,ovr,ferr,perr}", k), 32'(actv), 32'(expv));
    end
  endtask

  initial begin
    obs_t o, ob, oa;
    int   t, g, nev;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 57,  1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, -1,  1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 136, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 26,  1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b0, 1'b1, -1,  1'b1, 8'h07, 1'b1, 1'b0};
    tbl[5] = '{8'h07, 1'b1, 1'b1, 1'b1, -1,  1'b1, 8'h07, 1'b0, 1'b0};
    tbl[6] = '{8'h96, 1'b1, 1'b0, 1'b1, -1,  1'b1, 8'h96, 1'b0, 1'b0};

    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    o = grab_n();
    chk("reset n outputs", 32'(o), 32'(0));
    o = grab_p();
    chk("reset p outputs", 32'(o), 32'(0));

    for (int i = 0; i < 7; i++) begin
      do_reset();
      clear_wave();
      put_frame(0, tbl[i].data, tbl[i].par, tbl[i].pbit, tbl[i].stop);
      g = tbl[i].glitch;
      if (g >= 0) wave[g] = ~wave[g];
      t = tbl[i].par ? LATP : LAT;
      play(t + 4);
      o  = tbl[i].par ? obs_p[t]     : obs_n[t];
      ob = tbl[i].par ? obs_p[t - 1] : obs_n[t - 1];
      oa = tbl[i].par ? obs_p[t + 1] : obs_n[t + 1];
      chk($sformatf("row%0d nothing early", i), 32'({ob.v, ob.fe}), 32'(0));
      chk($sformatf("row%0d valid", i), 32'(o.v), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d data", i), 32'(o.d), 32'(tbl[i].e_data));
        chk($sformatf("row%0d parity_err", i), 32'(o.pe), 32'(tbl[i].e_perr));
      end
      chk($sformatf("row%0d frame_err", i), 32'(o.fe), 32'(tbl[i].e_ferr));
      chk($sformatf("row%0d frame_err one cycle", i), 32'(oa.fe), 32'(0));
      chk($sformatf("row%0d busy idle", i), 32'(o.busy), 32'(0));
    end

    // Short low pulse then a real frame
    do_reset();
    clear_wave();
    for (int k = 0; k < 4; k++) wave[k] = 1'b0;
    put_frame(30, 8'h3C, 1'b0, 1'b0, 1'b1);
    play(30 + LAT + 4);
    chk("falsestart busy at F+11", 32'(obs_n[11].busy), 32'(1));
    chk("falsestart busy at F+12", 32'(obs_n[12].busy), 32'(0));
    nev = 0;
    for (int k = 0; k < 30 + LAT; k++) nev += int'(obs_n[k].v) + int'(obs_n[k].fe);
    chk("falsestart no early output", 32'(nev), 32'(0));
    chk("falsestart follow valid", 32'(obs_n[30 + LAT].v), 32'(1));
    chk("falsestart follow data", 32'(obs_n[30 + LAT].d), 32'(8'h3C));

    // Overrun: two back-to-back frames with consumer stalled
    do_reset();
    clear_wave();
    put_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    put_frame(10 * C, 8'h22, 1'b0, 1'b0, 1'b1);
    for (int k = 330; k < 340; k++) rdyv[k] = 1'b1;
    play(340);
    nev = 0;
    for (int k = 0; k < 340; k++) nev += int'(obs_n[k].ov);
    chk("overrun pulse count", 32'(nev), 32'(1));
    chk("overrun pulse time", 32'(obs_n[10 * C + LAT].ov), 32'(1));
    chk("overrun data kept", 32'({obs_n[320].v, obs_n[320].d}), 32'({1'b1, 8'h11}));
    chk("overrun valid before accept", 32'(obs_n[329].v), 32'(1));
    chk("overrun valid after accept", 32'(obs_n[330].v), 32'(0));

    // Reset pulse during data bit 3, then a clean frame
    do_reset();
    clear_wave();
    put_frame(0, 8'hF8, 1'b0, 1'b0, 1'b1);
    rstv[70] = 1'b1;
    put_frame(200, 8'h5A, 1'b0, 1'b0, 1'b1);
    play(200 + LAT + 4);
    chk("midreset busy before", 32'(obs_n[69].busy), 32'(1));
    chk("midreset outputs cleared", 32'(obs_n[70]), 32'(0));
    nev = 0;
    for (int k = 0; k < 200 + LAT; k++) nev += int'(obs_n[k].v) + int'(obs_n[k].fe);
    chk("midreset no partial byte", 32'(nev), 32'(0));
    chk("midreset follow byte", 32'({obs_n[200 + LAT].v, obs_n[200 + LAT].d}), 32'({1'b1, 8'h5A}));

    random_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
